mips_multicycle_core: RTL and testbench

Multicycle successor to the single-cycle MIPS top: one shared ALU, one unified instruction/data memory port with a ready handshake, and an FSM sequencing each instruction over 3–5 cycles plus memory wait states. It sits between the testbench/SoC memory model and nothing else. It replaces the separate instruction and data ports with one port, so slow memories can stall the core. It also adds a parametrised reset vector, a parametrised address-bus width and explicit halt-on-illegal behaviour.

---
 rtl/mips_multicycle_core.sv | 207 ++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: shared ALU, single handshaked memory port, FSM sequencing.
// Define MIPS_BNE_EN to decode bne (opcode 000101); otherwise it is illegal and halts.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [3:0]        state,
  output logic              retire,
  output logic              halted
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
    S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
    S_HALT = 4'd15
  } state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_e;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_SLT = 6'h2a;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, rs_val, rt_val;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  logic r_ok, bne_ok, is_bne;
  assign r_ok   = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign is_bne = (opcode == OP_BNE);
`ifdef MIPS_BNE_EN
  assign bne_ok = is_bne;
`else
  assign bne_ok = 1'b0;
`endif

  // The single ALU serves PC+4, branch target, address calc, R-ops and branch compare.
  logic [31:0] alu_a, alu_b, alu_y;
  alu_e        alu_op;
  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    alu_a   = pc_q;
    alu_b   = 32'd4;
    alu_op  = ALU_ADD;
    rf_we   = 1'b0;
    rf_wa   = rt;
    rf_wd   = alu_q;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = alu_y;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        alu_b = {simm[29:0], 2'b00};
        alu_d = alu_y;
        case (opcode)
          OP_R:         state_d = r_ok ? S_EXEC : S_HALT;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = bne_ok ? S_BRANCH : S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_a   = a_q;
        alu_b   = simm;
        alu_d   = alu_y;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: if (mem_ready) begin
        mdr_d   = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = mdr_q;
        state_d = S_FETCH;
      end
      S_MEMWR: if (mem_ready) state_d = S_FETCH;
      S_EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        case (funct)
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_SLT:   alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        alu_d   = alu_y;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        rf_wa   = rd;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // Compare via subtract; bne inverts the zero test.
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = ALU_SUB;
        if ((alu_y == 32'd0) ^ is_bne) pc_d = alu_q;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_a   = a_q;
        alu_b   = simm;
        alu_d   = alu_y;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
    end
  end

  // Register file is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
  end

  logic        data_phase;
  logic [31:0] addr_full;
  assign data_phase = (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign addr_full  = data_phase ? alu_q : pc_q;
  assign mem_addr   = addr_full[ADDR_W-1:0] & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign mem_req    = reset && ((state_q == S_FETCH) || data_phase);
  assign mem_we     = (state_q == S_MEMWR);
  assign mem_wdata  = (state_q == S_MEMWR) ? b_q : 32'd0;
  assign retire     = (state_q inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP}) ||
                      ((state_q == S_MEMWR) && mem_ready);
  assign halted     = (state_q == S_HALT);
  assign pc         = pc_q;
  assign state      = state_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: memory model with random wait states plus an
// instruction-level reference model that predicts PC, latency, halt and memory image.
module tb_mips_multicycle_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, retire, halted;
  logic [31:0] mem_addr, mem_wdata, pc;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [3:0]  state;

  mips_multicycle_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .state(state), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ILL = 32'hFC00_0000;
  int checks = 0, passes = 0;
  logic [31:0] bmem  [256];
  logic [31:0] m_mem [256];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin bmem[i] = 32'd0; m_mem[i] = 32'd0; end
  endtask
  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    bmem[addr[9:2]] = w;
    m_mem[addr[9:2]] = w;
  endtask

  // Instruction-set model: executes one instruction, returns its base cycle count.
  task automatic model_step(output int base, output bit ill);
    logic [31:0] ir, a, b, simm, npc, ea;
    logic [4:0]  rs, rt, rd;
    ir = m_mem[m_pc[9:2]];
    rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
    a = m_reg[rs]; b = m_reg[rt];
    simm = {{16{ir[15]}}, ir[15:0]};
    ea = a + simm;
    npc = m_pc + 32'd4;
    base = 0; ill = 1'b0;
    case (ir[31:26])
      6'h00: begin
        base = 4;
        case (ir[5:0])
          6'h20: m_reg[rd] = a + b;
          6'h22: m_reg[rd] = a - b;
          6'h24: m_reg[rd] = a & b;
          6'h25: m_reg[rd] = a | b;
          6'h2a: m_reg[rd] = {31'd0, $signed(a) < $signed(b)};
          default: ill = 1'b1;
        endcase
      end
      6'h23: begin base = 5; m_reg[rt] = m_mem[ea[9:2]]; end
      6'h2b: begin base = 4; m_mem[ea[9:2]] = b; end
      6'h04: begin base = 3; if (a == b) npc = npc + (simm << 2); end
`ifdef MIPS_BNE_EN
      6'h05: begin base = 3; if (a != b) npc = npc + (simm << 2); end
`endif
      6'h08: begin base = 4; m_reg[rt] = a + simm; end
      6'h02: begin base = 3; npc = {npc[31:28], ir[25:0], 2'b00}; end
      default: ill = 1'b1;
    endcase
    m_reg[0] = 32'd0;
    m_pc = npc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Reset, run the loaded program until HALT, checking every retire against the model.
  task automatic run_prog(input int fw, input int dw, input bit rnd);
    int base, cyc, wins, wleft, budget;
    bit ill, pend, pcchk, done, wr, xfer;
    logic [31:0] paddr, wa, wd;
    do_reset();
    m_pc = 32'h0;
    checks++;
    if (!(mem_req === 1'b1 && mem_addr === 32'h0 && state === 4'd0))
      $display("FAIL first_fetch: req=%b addr=%h state=%0d, required req=1 addr=0 state=0",
               mem_req, mem_addr, state);
    else passes++;
    model_step(base, ill);
    cyc = 0; wins = 0; wleft = 0; pend = 0; pcchk = 0; done = 0; budget = 0;
    paddr = 32'h0;
    while (!done) begin
      if (pcchk) begin
        checks++;
        if (pc !== m_pc) $display("FAIL retire_pc: pc=%h required %h", pc, m_pc);
        else passes++;
        pcchk = 0;
        model_step(base, ill);
        cyc = 0; wins = 0;
      end
      if (mem_req === 1'b1) begin
        if (!pend) begin
          pend = 1; paddr = mem_addr;
          if (state !== 4'd0) wleft = rnd ? $urandom_range(0, dw) : dw;
          else wleft = rnd ? $urandom_range(0, fw) : fw;
        end else begin
          checks++;
          if (mem_addr !== paddr)
            $display("FAIL addr_stable: addr=%h required %h", mem_addr, paddr);
          else passes++;
        end
        mem_ready = (wleft == 0);
        if (wleft > 0) begin wleft--; wins++; end
      end else mem_ready = 1'b0;
      mem_rdata = bmem[mem_addr[9:2]];
      #1;
      cyc++;
      if (halted === 1'b1) begin
        checks++;
        if (!ill) $display("FAIL unexpected_halt: halted=1 required 0 at pc=%h", pc);
        else passes++;
        checks++;
        if (pc !== m_pc) $display("FAIL halt_pc: pc=%h required %h", pc, m_pc);
        else passes++;
        checks++;
        if (cyc !== 3 + wins) $display("FAIL halt_latency: %0d cycles required %0d", cyc, 3 + wins);
        else passes++;
        repeat (3) begin
          @(negedge clk);
          mem_ready = 1'b1;
          #1;
          checks++;
          if (mem_req !== 1'b0 || state !== 4'd15 || halted !== 1'b1)
            $display("FAIL halt_hold: req=%b state=%0d halted=%b required 0/15/1",
                     mem_req, state, halted);
          else passes++;
        end
        done = 1;
      end else if (retire === 1'b1) begin
        checks++;
        if (ill) $display("FAIL missing_halt: retired, required halt (pc model %h)", m_pc);
        else passes++;
        checks++;
        if (cyc !== base + wins)
          $display("FAIL latency: %0d cycles required %0d", cyc, base + wins);
        else passes++;
        checks++;
        if (state === 4'd0 || (mem_req === 1'b1 && mem_we === 1'b0))
          $display("FAIL retire_with_fetch: state=%0d req=%b we=%b", state, mem_req, mem_we);
        else passes++;
        pcchk = 1;
      end
      if (!done) begin
        wr = (mem_req === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1);
        xfer = (mem_req === 1'b1 && mem_ready === 1'b1);
        wa = mem_addr; wd = mem_wdata;
        @(posedge clk);
        if (wr) bmem[wa[9:2]] = wd;
        if (xfer) pend = 0;
        @(negedge clk);
        budget++;
        if (budget > 3000) begin
          checks++;
          $display("FAIL timeout: no halt within 3000 cycles, pc=%h", pc);
          done = 1;
        end
      end
    end
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (bmem[i] !== m_mem[i]) bad++;
      checks++;
      if (bad != 0) $display("FAIL mem_image: %0d words differ, required 0", bad);
      else passes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 4'd0 || pc !== 32'h0 || mem_req !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL reset_core: state=%0d pc=%h req=%b we=%b required 0/0/0/0",
               state, pc, mem_req, mem_we);
    else passes++;
    checks++;
    if (mem_wdata !== 32'h0 || mem_addr !== 32'h0 || retire !== 1'b0 || halted !== 1'b0)
      $display("FAIL reset_outs: wdata=%h addr=%h retire=%b halted=%b required all 0",
               mem_wdata, mem_addr, retire, halted);
    else passes++;
  endtask

  task automatic test_first_fetch();
    clear_mem();
    put(32'h0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h4, enc_i(6'h2b, 5'd0, 5'd1, 16'h0100));
    put(32'h8, ILL);
    run_prog(0, 0, 0);
    checks++;
    if (bmem[64] !== 32'd5) $display("FAIL addi_result: %h required 5", bmem[64]);
    else passes++;
  endtask

  task automatic test_lw_wait();
    clear_mem();
    put(32'h0, enc_i(6'h23, 5'd0, 5'd2, 16'h0008));
    put(32'h4, enc_i(6'h2b, 5'd0, 5'd2, 16'h0100));
    put(32'h8, 32'hDEADBEEF);
    run_prog(0, 2, 0);
    checks++;
    if (bmem[64] !== 32'hDEADBEEF) $display("FAIL lw_result: %h required deadbeef", bmem[64]);
    else passes++;
  endtask

  task automatic test_alu();
    logic [31:0] exp [6];
    clear_mem();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd7));
    put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h0C, enc_r(5'd1, 5'd2, 5'd4, 6'h22));
    put(32'h10, enc_r(5'd1, 5'd2, 5'd5, 6'h24));
    put(32'h14, enc_r(5'd1, 5'd2, 5'd6, 6'h25));
    put(32'h18, enc_r(5'd2, 5'd1, 5'd7, 6'h2a));
    put(32'h1C, enc_r(5'd1, 5'd2, 5'd8, 6'h2a));
    for (int r = 3; r <= 8; r++) put(32'h20 + 4 * (r - 3), enc_i(6'h2b, 5'd0, 5'(r), 16'(256 + 4 * r)));
    put(32'h38, ILL);
    run_prog(0, 0, 0);
    exp[0] = 32'd4; exp[1] = 32'd10; exp[2] = 32'd5;
    exp[3] = 32'hFFFF_FFFF; exp[4] = 32'd1; exp[5] = 32'd0;
    for (int r = 3; r <= 8; r++) begin
      checks++;
      if (bmem[64 + r] !== exp[r - 3])
        $display("FAIL alu_r%0d: %h required %h", r, bmem[64 + r], exp[r - 3]);
      else passes++;
    end
  endtask

  task automatic test_branch_jump();
    clear_mem();
    put(32'h000, enc_j(26'h4));
    put(32'h004, enc_j(26'h40));
    put(32'h010, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFC));
    put(32'h100, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
    put(32'h104, enc_i(6'h2b, 5'd0, 5'd0, 16'h0200));
    put(32'h108, ILL);
    put(32'h200, 32'h1234_5678);
    run_prog(1, 1, 1);
    checks++;
    if (bmem[128] !== 32'd0) $display("FAIL r0_write: $0 stored %h required 0", bmem[128]);
    else passes++;
    checks++;
    if (pc !== 32'h10C) $display("FAIL jump_path: halt pc=%h required 10c", pc);
    else passes++;
  endtask

  task automatic test_illegal_and_mid_reset();
    int seen;
    clear_mem();
    put(32'h0, ILL);
    run_prog(0, 0, 0);
    checks++;
    if (halted !== 1'b1 || state !== 4'd15 || mem_req !== 1'b0)
      $display("FAIL illegal: halted=%b state=%0d req=%b required 1/15/0", halted, state, mem_req);
    else passes++;
    clear_mem();
    put(32'h0, enc_i(6'h23, 5'd0, 5'd2, 16'h0008));
    put(32'h4, enc_i(6'h2b, 5'd0, 5'd2, 16'h0100));
    put(32'h8, 32'hDEADBEEF);
    do_reset();
    seen = 0;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      if (state === 4'd3) seen++;
      if (seen < 3) begin
        mem_ready = (state !== 4'd3);
        mem_rdata = bmem[mem_addr[9:2]];
        @(negedge clk);
      end
    end
    checks++;
    if (state !== 4'd3 || mem_req !== 1'b1 || mem_addr !== 32'h8)
      $display("FAIL memrd_wait: state=%0d req=%b addr=%h required 3/1/8", state, mem_req, mem_addr);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || state !== 4'd0 || pc !== 32'h0 || mem_addr !== 32'h0)
      $display("FAIL mid_reset: req=%b state=%0d pc=%h addr=%h required 0/0/0/0",
               mem_req, state, pc, mem_addr);
    else passes++;
    run_prog(0, 1, 1);
    checks++;
    if (bmem[64] !== 32'hDEADBEEF) $display("FAIL restart_lw: %h required deadbeef", bmem[64]);
    else passes++;
  endtask

  task automatic test_bne();
    clear_mem();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd2));
    put(32'h08, enc_i(6'h05, 5'd1, 5'd2, 16'd2));
    put(32'h0C, enc_i(6'h08, 5'd0, 5'd3, 16'd7));
    put(32'h10, ILL);
    put(32'h14, enc_i(6'h2b, 5'd0, 5'd1, 16'h0100));
    put(32'h18, ILL);
    run_prog(0, 0, 0);
    checks++;
`ifdef MIPS_BNE_EN
    if (bmem[64] !== 32'd1 || pc !== 32'h1C)
      $display("FAIL bne_taken: stored %h pc=%h required 1 and 1c", bmem[64], pc);
    else passes++;
`else
    if (halted !== 1'b1 || pc !== 32'h0C)
      $display("FAIL bne_illegal: halted=%b pc=%h required 1 and c", halted, pc);
    else passes++;
`endif
  endtask

  task automatic test_random();
    logic [5:0] fns [5];
    logic [31:0] a;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a;
    for (int it = 0; it < 3; it++) begin
      clear_mem();
      a = 32'h0;
      for (int r = 1; r <= 7; r++) begin
        put(a, enc_i(6'h08, 5'd0, 5'(r), 16'($urandom))); a += 4;
      end
      for (int w = 192; w < 256; w++) put(32'(w * 4), $urandom);
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 3))
          0: put(a, enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]));
          1: put(a, enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)));
          2: put(a, enc_i(6'h23, 5'd0, 5'($urandom_range(1, 7)), 16'(32'h300 + 4 * $urandom_range(0, 63))));
          default: put(a, enc_i(6'h2b, 5'd0, 5'($urandom_range(0, 7)), 16'(32'h300 + 4 * $urandom_range(0, 63))));
        endcase
        a += 4;
      end
      for (int r = 1; r <= 7; r++) begin
        put(a, enc_i(6'h2b, 5'd0, 5'(r), 16'(32'h200 + 4 * r))); a += 4;
      end
      put(a, ILL);
      run_prog(2, 3, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    test_reset();
    test_first_fetch();
    test_lw_wait();
    test_alu();
    test_branch_jump();
    test_illegal_and_mid_reset();
    test_bne();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
